// File: rtl/conv_accumulator_if.sv
// Handshake bundle for conv_accumulator: partial-sum input stream and finished-pixel output stream.
// master = upstream ALU / downstream store side, slave = accumulator side.
interface conv_accumulator_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_accumulator.sv
// Convolution accumulator: sums num_terms signed partials onto a bias and emits one 32-bit saturated result.
// Optional macro CONV_ACC_RELU_EN zeroes negative results after saturation (out_sat unaffected).
module conv_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_terms,
  input  logic [31:0]              bias,
  conv_accumulator_if.slave        bus,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        terms;
  logic                    accept;
  logic                    last;
  logic [ACC_W-32:0]       upper;
  logic                    in_range;
  logic [31:0]             sat_data;
  logic                    sat_flag;

  function automatic logic signed [ACC_W-1:0] sext32(input logic [31:0] v);
    return {{(ACC_W-32){v[31]}}, v};
  endfunction

  assign accept = (state == ACCUM) && bus.in_valid;
  assign last   = (cnt == terms - CNT_W'(1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting every always_comb output first keeps any path from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_terms == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator is sized so the worst-case job can never wrap; only the output clamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      terms <= '0;
    end else if (state == IDLE && start) begin
      acc   <= sext32(bias);
      cnt   <= '0;
      terms <= num_terms;
    end else if (accept) begin
      acc <= acc + sext32(bus.in_data);
      cnt <= cnt + CNT_W'(1);
    end
  end

  // acc fits in 32 bits exactly when bits [ACC_W-1:31] are all copies of the sign.
  assign upper    = acc[ACC_W-1:31];
  assign in_range = (&upper) || !(|upper);

  always_comb begin
    sat_flag = !in_range;
    if (in_range)          sat_data = acc[31:0];
    else if (acc[ACC_W-1]) sat_data = 32'h8000_0000;
    else                   sat_data = 32'h7FFF_FFFF;
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_sat   = 1'b0;
    busy          = (state != IDLE);
    case (state)
      ACCUM: bus.in_ready = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_sat   = sat_flag;
`ifdef CONV_ACC_RELU_EN
        bus.out_data  = sat_data[31] ? 32'h0 : sat_data;
`else
        bus.out_data  = sat_data;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed vector table, multi-cycle corner sequences,
// and randomized jobs against a plain-arithmetic reference model.
module tb_conv_accumulator;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic [31:0]      bias = '0;
  logic             busy;

  int errors = 0;
  int checks = 0;

  conv_accumulator_if bus ();

  conv_accumulator #(.ACC_W(40), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .bias      (bias),
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [31:0] b;
    logic [31:0] p[4];
    int          gap;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_sat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu_exp(input logic [31:0] d);
`ifdef CONV_ACC_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  // Reference: exact sum in 64-bit arithmetic, then clamp to int32, then optional ReLU.
  function automatic logic [32:0] model(input logic [31:0] b, input logic [31:0] q[$]);
    longint      s;
    logic [31:0] d;
    logic        sat;
    s = longint'($signed(b));
    foreach (q[i]) s += longint'($signed(q[i]));
    if (s > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF; sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      d = 32'h8000_0000; sat = 1'b1;
    end else begin
      d = s[31:0]; sat = 1'b0;
    end
    return {sat, relu_exp(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE; start is pulsed during gaps and stalls to show it is ignored.
  task automatic run_job(input string name, input int n, input logic [31:0] b,
                         input logic [31:0] q[$], input int gap, input int stall,
                         input logic [31:0] exp_d, input logic exp_s);
    start = 1'b1; num_terms = CNT_W'(n); bias = b;
    tick();
    start = 1'b0;
    check({name, "/busy_after_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < q.size(); k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0; start = 1'b1;
        tick();
      end
      start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = q[k];
      check({name, "/in_ready_accum"}, 32'(bus.in_ready), 32'd1);
      check({name, "/no_early_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0; bus.in_data = 32'hDEAD_BEEF;
    check({name, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "/out_data"}, bus.out_data, exp_d);
    check({name, "/out_sat"}, 32'(bus.out_sat), 32'(exp_s));
    check({name, "/in_ready_done"}, 32'(bus.in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0; start = 1'b1;
      tick();
      check({name, "/stall_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "/stall_data"}, bus.out_data, exp_d);
      check({name, "/stall_busy"}, 32'(busy), 32'd1);
    end
    bus.out_ready = 1'b1; start = 1'b1;
    tick();
    bus.out_ready = 1'b0; start = 1'b0;
    check({name, "/valid_after_hs"}, 32'(bus.out_valid), 32'd0);
    check({name, "/busy_after_hs"}, 32'(busy), 32'd0);
    check({name, "/data_idle"}, bus.out_data, 32'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] q[$];
  logic [32:0] m;

  initial begin
    vecs[0] = '{n:3, b:32'd10,        p:'{32'd5, 32'hFFFF_FFFE, 32'd7, 32'd0},
                gap:0, stall:0, exp_data:32'd20,        exp_sat:1'b0};
    vecs[1] = '{n:0, b:32'hFFFF_FFFC, p:'{32'd0, 32'd0, 32'd0, 32'd0},
                gap:0, stall:1, exp_data:32'hFFFF_FFFC, exp_sat:1'b0};
    vecs[2] = '{n:2, b:32'd0,         p:'{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0},
                gap:0, stall:0, exp_data:32'h7FFF_FFFF, exp_sat:1'b1};
    vecs[3] = '{n:2, b:32'd0,         p:'{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0},
                gap:0, stall:0, exp_data:32'h8000_0000, exp_sat:1'b1};
    vecs[4] = '{n:4, b:32'd100,       p:'{32'd1000, 32'hFFFF_FFCE, 32'd3, 32'hFFFF_FFFD},
                gap:2, stall:5, exp_data:32'd1050,      exp_sat:1'b0};
    vecs[5] = '{n:1, b:32'hFFFF_FFFF, p:'{32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0},
                gap:1, stall:0, exp_data:32'hFFFF_FFFA, exp_sat:1'b0};
    vecs[6] = '{n:2, b:32'h7FFF_FFFF, p:'{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0},
                gap:0, stall:2, exp_data:32'h7FFF_FFFF, exp_sat:1'b0};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    repeat (3) tick();
    check("reset/in_ready",  32'(bus.in_ready),  32'd0);
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/out_data",  bus.out_data,       32'd0);
    check("reset/out_sat",   32'(bus.out_sat),   32'd0);
    check("reset/busy",      32'(busy),          32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      q = {};
      for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].p[k]);
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].b, q, vecs[i].gap, vecs[i].stall,
              relu_exp(vecs[i].exp_data), vecs[i].exp_sat);
    end

    // Reset after 2 of 4 partials abandons the job.
    start = 1'b1; num_terms = CNT_W'(4); bias = 32'd50;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h4000_0000;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    check("midrst/in_ready",  32'(bus.in_ready),  32'd0);
    check("midrst/out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst/out_data",  bus.out_data,       32'd0);
    check("midrst/out_sat",   32'(bus.out_sat),   32'd0);
    check("midrst/busy",      32'(busy),          32'd0);
    tick();
    q = {32'd1};
    run_job("rst_recover", 1, 32'd1, q, 0, 0, 32'd2, 1'b0);

    // Maximum-length job at the most negative extreme: total is exactly -2^39.
    q = {};
    for (int k = 0; k < 255; k++) q.push_back(32'h8000_0000);
    run_job("max_terms", 255, 32'h8000_0000, q, 0, 1, relu_exp(32'h8000_0000), 1'b1);

    for (int j = 0; j < 40; j++) begin
      int          n;
      logic [31:0] b;
      n = $urandom_range(0, 6);
      b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      q = {};
      for (int k = 0; k < n; k++)
        q.push_back($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100);
      m = model(b, q);
      run_job($sformatf("rand%0d", j), n, b, q, $urandom_range(0, 2), $urandom_range(0, 2),
              m[31:0], m[32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
